// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the LCD GDRAM receiver: FSM states, command
// opcode/mask pairs and the 128x64 GDRAM geometry.
package lcd_rx_pkg;

    typedef enum logic {
        S_CMD    = 1'b0,
        S_WAIT_X = 1'b1
    } state_t;

    // Command opcodes are matched as (data & MASK) == OP.
    localparam logic [7:0] SET_ADDR_MASK   = 8'h80;
    localparam logic [7:0] SET_ADDR_OP     = 8'h80;
    localparam logic [7:0] FUNC_SET_MASK   = 8'hE0;
    localparam logic [7:0] FUNC_SET_OP     = 8'h20;
    localparam logic [7:0] DISP_CTRL_MASK  = 8'hF8;
    localparam logic [7:0] DISP_CTRL_OP    = 8'h08;
    localparam logic [7:0] ENTRY_MODE_MASK = 8'hFC;
    localparam logic [7:0] ENTRY_MODE_OP   = 8'h04;
    localparam logic [7:0] ENTRY_MODE_OK   = 8'h06;
    localparam logic [7:0] CLEAR_CMD       = 8'h01;

    localparam int GD_WORDS   = 16;
    localparam int GD_ROWS    = 32;
    localparam int GD_HALVES  = 2;
    localparam int GD_ADDR_W  = 10;
    localparam logic [GD_ADDR_W-1:0] GD_LAST_ADDR =
        GD_ADDR_W'(GD_WORDS * GD_ROWS * GD_HALVES - 1);

    function automatic logic op_match(input logic [7:0] d,
                                      input logic [7:0] mask,
                                      input logic [7:0] op);
        return (d & mask) == op;
    endfunction

    // The upper/lower screen halves are selected by x[3], so it lands on the MSB.
    function automatic logic [GD_ADDR_W-1:0] gd_addr(input logic [3:0] x,
                                                     input logic [4:0] y,
                                                     input logic       hl);
        return {x[3], y, x[2:0], hl};
    endfunction

endpackage

// File: rtl/lcd_en_sync.sv
// Two-flop synchronizer for the asynchronous lcd_en strobe, with one-cycle
// falling- and rising-edge pulses derived from the synchronized level.
module lcd_en_sync (
    input  logic clk,
    input  logic rst,
    input  logic lcd_en,
    output logic strb_fall,
    output logic strb_rise
);

    logic [1:0] sync_q;
    logic       en_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b00;
            en_prev <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], lcd_en};
            en_prev <= sync_q[1];
        end
    end

    assign strb_fall = en_prev & ~sync_q[1];
    assign strb_rise = ~en_prev & sync_q[1];

endmodule

// File: rtl/lcd_gdram_rx.sv
// LCD-side responder: decodes the 8-bit parallel LCD instruction stream and
// turns data bytes into single-cycle GDRAM byte writes. Optional read-back
// path is enabled by defining LCD_RX_BUSY_RD_EN.
import lcd_rx_pkg::*;

module lcd_gdram_rx #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lcd_rs,
    input  logic              lcd_rw,
    input  logic              lcd_en,
    input  logic [7:0]        lcd_data,
    output logic [7:0]        lcd_dout,
    output logic              lcd_doe,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              disp_on,
    output logic              ext_mode,
    output logic              graphic_on,
    output logic              frame_done,
    output logic              cmd_err
);

    logic       strb_fall;
    logic       strb_rise;

    logic       cap_vld;
    logic       cap_rs;
    logic       cap_rw;
    logic [7:0] cap_data;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] x;
    logic [4:0] y;
    logic       hl;

    logic       act_write;
    logic       act_err;
    logic       act_set_y;
    logic       act_set_x;
    logic       act_func;
    logic       act_disp;
    logic       act_clear;

    logic [GD_ADDR_W-1:0] cur_addr;

    lcd_en_sync u_en_sync (
        .clk       (clk),
        .rst       (rst),
        .lcd_en    (lcd_en),
        .strb_fall (strb_fall),
        .strb_rise (strb_rise)
    );

    // Bus pins are stable while en is low, so sampling on the synchronized fall is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld  <= 1'b0;
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= 8'h00;
        end else begin
            cap_vld <= strb_fall;
            if (strb_fall) begin
                cap_rs   <= lcd_rs;
                cap_rw   <= lcd_rw;
                cap_data <= lcd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_CMD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (act_set_y)
            state_nxt = S_WAIT_X;
        else if (state == S_WAIT_X && cap_vld && !cap_rw)
            state_nxt = S_CMD;
    end

    // NOTE: every signal gets a default before the case, otherwise the paths
    // that do not assign it would infer a latch.
    always_comb begin
        act_write = 1'b0;
        act_err   = 1'b0;
        act_set_y = 1'b0;
        act_set_x = 1'b0;
        act_func  = 1'b0;
        act_disp  = 1'b0;
        act_clear = 1'b0;
        if (cap_vld && !cap_rw) begin
            unique case (state)
                S_CMD: begin
                    if (cap_rs) begin
                        act_write = ext_mode;
                        act_err   = ~ext_mode;
                    end else if (op_match(cap_data, SET_ADDR_MASK, SET_ADDR_OP)) begin
                        act_set_y = ext_mode;
                    end else if (op_match(cap_data, FUNC_SET_MASK, FUNC_SET_OP)) begin
                        act_func = 1'b1;
                    end else if (op_match(cap_data, DISP_CTRL_MASK, DISP_CTRL_OP)) begin
                        act_disp = 1'b1;
                    end else if (op_match(cap_data, ENTRY_MODE_MASK, ENTRY_MODE_OP)) begin
                        act_err = (cap_data != ENTRY_MODE_OK);
                    end else if (cap_data == CLEAR_CMD) begin
                        act_clear = 1'b1;
                    end
                end
                S_WAIT_X: begin
                    if (!cap_rs && op_match(cap_data, SET_ADDR_MASK, SET_ADDR_OP))
                        act_set_x = 1'b1;
                    else
                        act_err = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cur_addr = gd_addr(x, y, hl);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
            disp_on    <= 1'b0;
            ext_mode   <= 1'b0;
            graphic_on <= 1'b0;
            x          <= 4'd0;
            y          <= 5'd0;
            hl         <= 1'b0;
        end else begin
            wr_en      <= act_write;
            wr_addr    <= act_write ? ADDR_W'(cur_addr) : '0;
            wr_data    <= act_write ? cap_data : 8'h00;
            frame_done <= act_write && (cur_addr == GD_LAST_ADDR);
            cmd_err    <= act_err;

            if (act_func) begin
                ext_mode <= cap_data[2];
                if (cap_data[2])
                    graphic_on <= cap_data[1];
            end
            if (act_disp)
                disp_on <= cap_data[2];

            if (act_set_y)
                y <= cap_data[4:0];
            if (act_set_x) begin
                x  <= cap_data[3:0];
                hl <= 1'b0;
            end
            if (act_clear) begin
                x  <= 4'd0;
                y  <= 5'd0;
                hl <= 1'b0;
            end
            // x advances after the low byte of a word; 4-bit wrap gives 15 -> 0.
            if (act_write) begin
                hl <= ~hl;
                if (hl)
                    x <= x + 4'd1;
            end
        end
    end

`ifdef LCD_RX_BUSY_RD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_doe  <= 1'b0;
            lcd_dout <= 8'h00;
        end else if (cap_vld && cap_rw) begin
            lcd_doe  <= 1'b1;
            lcd_dout <= cap_rs ? 8'h00 : {3'b000, x, hl};
        end else if (strb_rise) begin
            lcd_doe <= 1'b0;
        end
    end
`else
    assign lcd_dout = 8'h00;
    assign lcd_doe  = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_gdram_rx.sv
// Directed self-checking bench for lcd_gdram_rx: drives the LCD bus with slow
// en strobes and logs every write/error pulse observed on the falling clock edge.
module tb_lcd_gdram_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_en = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [7:0] lcd_dout;
    logic       lcd_doe;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       disp_on;
    logic       ext_mode;
    logic       graphic_on;
    logic       frame_done;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    int wr_cnt   = 0;
    int err_cnt  = 0;
    int fd_cnt   = 0;
    int wide_cnt = 0;
    logic       wr_prev  = 1'b0;
    logic       err_prev = 1'b0;
    logic [9:0] addr_log [64];
    logic [7:0] data_log [64];
    logic       fd_log   [64];

    lcd_gdram_rx #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data   (lcd_data),
        .lcd_dout   (lcd_dout),
        .lcd_doe    (lcd_doe),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .disp_on    (disp_on),
        .ext_mode   (ext_mode),
        .graphic_on (graphic_on),
        .frame_done (frame_done),
        .cmd_err    (cmd_err)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (wr_cnt < 64) begin
                    addr_log[wr_cnt] = wr_addr;
                    data_log[wr_cnt] = wr_data;
                    fd_log[wr_cnt]   = frame_done;
                end
                wr_cnt = wr_cnt + 1;
            end
            if (frame_done) fd_cnt = fd_cnt + 1;
            if (cmd_err)    err_cnt = err_cnt + 1;
            if ((wr_en && wr_prev) || (cmd_err && err_prev)) wide_cnt = wide_cnt + 1;
            wr_prev  = wr_en;
            err_prev = cmd_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic rs, input logic [7:0] d);
        lcd_rs   = rs;
        lcd_rw   = 1'b0;
        lcd_data = d;
        repeat (2) @(negedge clk);
        lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        lcd_en = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    int w0, e0, f0;
    logic [9:0] exp_addr [4];
    logic [7:0] exp_data [4];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 0);
        check("rst_outs", {26'd0, disp_on, ext_mode, graphic_on, frame_done, cmd_err, lcd_doe}, 0);
        check("rst_addr_data", {14'd0, wr_addr, wr_data}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Initialization sequence
        w0 = wr_cnt; e0 = err_cnt;
        bus_wr(1'b0, 8'h30);
        bus_wr(1'b0, 8'h06);
        bus_wr(1'b0, 8'h0C);
        bus_wr(1'b0, 8'h36);
        check("init_disp_on", {31'd0, disp_on}, 1);
        check("init_ext_mode", {31'd0, ext_mode}, 1);
        check("init_graphic_on", {31'd0, graphic_on}, 1);
        check("init_no_wr", wr_cnt - w0, 0);
        check("init_no_err", err_cnt - e0, 0);

        // Writes from address 0
        w0 = wr_cnt; f0 = fd_cnt;
        bus_wr(1'b0, 8'h80);
        bus_wr(1'b0, 8'h80);
        bus_wr(1'b1, 8'hAA);
        bus_wr(1'b1, 8'h55);
        bus_wr(1'b1, 8'h01);
        bus_wr(1'b1, 8'h02);
        check("seq0_wr_count", wr_cnt - w0, 4);
        check("seq0_no_fd", fd_cnt - f0, 0);
        exp_data = '{8'hAA, 8'h55, 8'h01, 8'h02};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("seq0_addr%0d", i), {22'd0, addr_log[w0 + i]}, i);
            check($sformatf("seq0_data%0d", i), {24'd0, data_log[w0 + i]}, {24'd0, exp_data[i]});
        end

        // Last word of the frame, then x wraps
        w0 = wr_cnt; f0 = fd_cnt;
        bus_wr(1'b0, 8'h9F);
        bus_wr(1'b0, 8'h8F);
        bus_wr(1'b1, 8'h11);
        bus_wr(1'b1, 8'h22);
        bus_wr(1'b1, 8'h33);
        check("end_wr_count", wr_cnt - w0, 3);
        check("end_fd_count", fd_cnt - f0, 1);
        exp_addr = '{10'd1022, 10'd1023, 10'd496, 10'd0};
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h00};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("end_addr%0d", i), {22'd0, addr_log[w0 + i]}, {22'd0, exp_addr[i]});
            check($sformatf("end_data%0d", i), {24'd0, data_log[w0 + i]}, {24'd0, exp_data[i]});
            check($sformatf("end_fd%0d", i), {31'd0, fd_log[w0 + i]}, (i == 1) ? 1 : 0);
        end

        // Out-of-sequence data after a Y set
        w0 = wr_cnt; e0 = err_cnt;
        bus_wr(1'b0, 8'h85);
        bus_wr(1'b1, 8'h77);
        check("wait_x_err", err_cnt - e0, 1);
        check("wait_x_no_wr", wr_cnt - w0, 0);
        bus_wr(1'b0, 8'h83);
        bus_wr(1'b1, 8'h66);
        check("new_y_err", err_cnt - e0, 2);
        check("new_y_no_wr", wr_cnt - w0, 0);
        bus_wr(1'b0, 8'h80);
        bus_wr(1'b0, 8'h80);
        bus_wr(1'b1, 8'h99);
        check("recover_wr", wr_cnt - w0, 1);
        check("recover_addr", {22'd0, addr_log[w0]}, 0);
        check("recover_data", {24'd0, data_log[w0]}, 32'h99);

        // Basic mode: data dropped, bad entry mode
        w0 = wr_cnt; e0 = err_cnt;
        bus_wr(1'b0, 8'h30);
        check("basic_ext_off", {31'd0, ext_mode}, 0);
        check("basic_graphic_kept", {31'd0, graphic_on}, 1);
        bus_wr(1'b1, 8'h5A);
        check("basic_data_err", err_cnt - e0, 1);
        check("basic_no_wr", wr_cnt - w0, 0);
        bus_wr(1'b0, 8'h04);
        check("entry_bad_err", err_cnt - e0, 2);

        // Mid-stream reset
        bus_wr(1'b0, 8'h36);
        check("pre_rst_ext", {31'd0, ext_mode}, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_status", {29'd0, disp_on, ext_mode, graphic_on}, 0);
        check("mid_rst_pulses", {29'd0, wr_en, frame_done, cmd_err}, 0);
        check("mid_rst_bus", {14'd0, wr_addr, wr_data}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        w0 = wr_cnt; e0 = err_cnt;
        bus_wr(1'b1, 8'h3C);
        check("post_rst_err", err_cnt - e0, 1);
        check("post_rst_no_wr", wr_cnt - w0, 0);

        check("pulse_width", wide_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
